// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use and HI/LO stalls, taken-branch flush,
// MEM wait-state extension and a counter-based multiply/divide occupancy FSM.
module hazard_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dirty,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_uses_hilo,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_taken,
    input  logic        ex_md_start,
    input  logic        ex_md_div,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic [4:0]  extend,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // The start cycle and the done cycle each account for one cycle of occupancy.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    md_state_t  state, state_next;
    logic [5:0] cnt, cnt_next;

    logic id_ok, ex_ok, mem_ok;
    logic mem_hold;
    logic ex_extend;
    logic ex_hold;
    logic load_use;
    logic hilo;
    logic stall_id;
    logic flush_id;

    // IF and WB dirty bits do not influence any hazard decision.
    logic unused_dirty;
    assign unused_dirty = &{1'b0, dirty[4], dirty[0]};

    assign id_ok  = !dirty[3];
    assign ex_ok  = !dirty[2];
    assign mem_ok = !dirty[1];

    assign mem_hold = mem_ok & mem_req & !mem_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ex_extend  = 1'b0;
        md_done    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_ok && ex_md_start && !mem_hold) begin
                    ex_extend  = 1'b1;
                    cnt_next   = ex_md_div ? DIV_LOAD : MUL_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 6'd0) begin
                    ex_extend = 1'b1;
                    cnt_next  = cnt - 6'd1;
                end else if (!mem_hold) begin
                    md_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign md_busy = (state == BUSY);
    assign ex_hold = mem_hold | ex_extend;

    assign load_use = id_ok & ex_ok & ex_load & (ex_rd != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    assign hilo     = id_ok & id_uses_hilo & (md_busy | (ex_ok & ex_md_start));
    assign stall_id = load_use | hilo;

    // A redirect waits while EX is held, so it lands in the releasing cycle.
    assign flush_id = ex_ok & ex_taken & !ex_hold;

    assign stall  = {1'b0, stall_id, 3'b000};
    assign flush  = {1'b0, flush_id, 3'b000};
    assign extend = {2'b00, ex_extend, mem_hold, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (stall_id && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Generates the per-stage stall, flush and extend request vectors consumed by the five-stage pipeline control unit, and receives that unit's per-stage dirty vector back. It detects load-use and HI/LO hazards in ID, branch redirects resolved in EX, memory wait states in MEM and multi-cycle multiply/divide occupancy in EX. The multiply/divide sequencing is a counter-based FSM inside this block. Stage bit order on every 5-bit vector: bit4=IF, bit3=ID, bit2=EX, bit1=MEM, bit0=WB.

## Interface
- MUL_CYCLES, 4, total EX occupancy of a multiply in cycles (2..63)
- DIV_CYCLES, 32, total EX occupancy of a divide in cycles (2..63)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- dirty  in  5  per-stage dirty vector from the pipeline control unit (1 = stage holds a bubble)
- id_rs, id_rt  in  5 each  source register numbers of the ID instruction
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_uses_hilo  in  1  ID instruction reads HI/LO
- ex_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_taken  in  1  EX branch/jump resolved taken
- ex_md_start  in  1  EX instruction is mult/div
- ex_md_div  in  1  1 = divide, 0 = multiply (valid with ex_md_start)
- mem_req  in  1  MEM instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- stall  out  5  stall requests; only bit3 driven, others 0
- flush  out  5  flush requests; only bit3 driven, others 0
- extend  out  5  extend requests; bits 2 and 1 driven, others 0
- md_busy  out  1  mult/div FSM in BUSY
- md_done  out  1  one-cycle pulse, mult/div result valid
- stall_cycles  out  16  saturating count of cycles with stall[3]=1

## Operation
- ex_ok = !dirty[2]; id_ok = !dirty[3]; mem_ok = !dirty[1].
- mem_hold = mem_ok & mem_req & !mem_ready; extend[1] = mem_hold.
- MD FSM states IDLE, BUSY; 6-bit counter cnt.
  - IDLE: if ex_ok & ex_md_start & !mem_hold: extend[2]=1, cnt <= (div ? DIV_CYCLES : MUL_CYCLES) - 2, -> BUSY. Otherwise extend[2]=0.
  - BUSY, cnt!=0: extend[2]=1, cnt <= cnt-1.
  - BUSY, cnt==0: extend[2]=0; if !mem_hold: md_done=1, -> IDLE; else stay BUSY with cnt=0 and md_done=0.
  - md_busy = (state==BUSY).
- ex_hold = extend[1] | extend[2].
- Load-use: lu = id_ok & ex_ok & ex_load & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- HI/LO: hl = id_ok & id_uses_hilo & (md_busy | (ex_ok & ex_md_start)).
- stall[3] = lu | hl.
- Redirect: flush[3] = ex_ok & ex_taken & !ex_hold. The flush is deferred while EX is held and fires exactly once, in the cycle EX releases.
- stall_cycles increments when stall[3]=1 and saturates at 16'hFFFF.
- All outputs are combinational from the current inputs and state, except stall_cycles, which is registered.

## Timing
- Reset (rst=1 at an edge): state=IDLE, cnt=0, stall_cycles=0. In the cycle after reset, with dirty=5'b11111, all of stall/flush/extend are 0 and md_busy=md_done=0.
- Reset mid-BUSY aborts the operation. No md_done is produced.
- Mult/div occupancy is exactly N cycles with no mem_hold: extend[2]=1 for N-1 cycles, then md_done is asserted in cycle N with extend[2]=0.
- mem_hold in the start cycle delays the start. The FSM samples again on the next cycle.
- Simultaneous lu and ex_taken: both are asserted, and the pipeline control unit resolves priority.
- A load in EX with ex_rd=0 never stalls.

## Test plan
- Load-use: ex_load=1, ex_rd=5, id_rs=5, id_uses_rs=1, dirty=0 -> stall=5'b01000 for 1 cycle; stall_cycles goes 0->1. The same stimulus with ex_rd=0 -> stall=0.
- Multiply: ex_md_start=1, ex_md_div=0, MUL_CYCLES=4 -> extend[2]=1 on T0..T2; md_done=1 and extend[2]=0 on T3; md_busy=1 on T1..T3.
- Divide with a MEM wait: DIV_CYCLES=32, mem_req=1, mem_ready=0 held from T31 through T33 -> extend=5'b00010 on T31..T33; md_done on T34 only.
- Branch under hold: ex_taken=1 while mem_hold=1 for 3 cycles -> flush=0 for those 3 cycles, then flush=5'b01000 for exactly 1 cycle when mem_ready=1.
- HI/LO: id_uses_hilo=1 during a BUSY multiply -> stall[3]=1 every BUSY cycle. The same stimulus with dirty[3]=1 -> stall=0.
- Reset mid-divide at T10 -> md_busy=0 and extend=0 the next cycle, no md_done, and stall_cycles=0.
